fft_out_reorder: RTL and testbench
==================================

FFT_OUT_REORDER -- requirements
Module: fft_out_reorder

Interface
REQ-001: Parameter DATA_WIDTH, default 12, sets the width of each real and imaginary sample.
REQ-002: clk  input  1  single clock; all logic updates on the rising edge.
REQ-003: rst_n  input  1  reset; synchronous and active-low.
REQ-004: valid_out  input  1  FFT output sample valid.
REQ-005: X_r  input  DATA_WIDTH signed  FFT output real part.
REQ-006: X_i  input  DATA_WIDTH signed  FFT output imaginary part.
REQ-007: stall  output  1  freezes the FFT pipeline; the FFT holds valid_out, X_r and X_i stable while stall=1.
REQ-008: out_ready  input  1  downstream can accept a sample.
REQ-009: out_valid  output  1  out_r, out_i, out_idx and out_last are valid.
REQ-010: out_r, out_i  output  DATA_WIDTH signed  reordered sample.
REQ-011: out_idx  output  4  natural-order bin index of the current output.
REQ-012: out_last  output  1  high when out_valid=1 and out_idx=15.

Function
REQ-013: Storage SHALL be two banks (0 and 1) of 16 complex words each, with a full flag per bank, used ping-pong.
REQ-014: A sample SHALL be accepted on a cycle where valid_out=1 and stall=0; no other input cycle writes storage.
REQ-015: A write counter wr_cnt (0..15) SHALL select the write address within bank wr_bank, and SHALL increment on each accept.
REQ-016: On the accept at wr_cnt=15, full[wr_bank] SHALL set, wr_bank SHALL toggle, and wr_cnt SHALL wrap to 0.
REQ-017: stall SHALL equal full[wr_bank], decoded from registered state only (no combinational path from valid_out or out_ready).
REQ-018: out_valid SHALL equal full[rd_bank].
REQ-019: The output data SHALL be a combinational read of bank[rd_bank][rd_idx]; out_idx SHALL equal rd_idx.
REQ-020: A transfer SHALL occur when out_valid=1 and out_ready=1, and SHALL increment rd_idx.
REQ-021: On the transfer at rd_idx=15, full[rd_bank] SHALL clear, rd_bank SHALL toggle, and rd_idx SHALL wrap to 0.
REQ-022: out_r and out_i SHALL read 0 while out_valid=0.
REQ-023: Latency: out_valid SHALL rise on the cycle after the clock edge that accepts the 16th sample of a frame.
REQ-024: When set and clear of the same bank's full flag are requested on the same edge, both SHALL take effect (each bank has a distinct role), with no loss of sample or frame.
REQ-025: When a full bank is freed, stall SHALL deassert on the following cycle; one bubble cycle is accepted behaviour.
REQ-026: Frames SHALL be output in arrival order; at most two frames are buffered.
REQ-027: Once out_valid=1, it and the output data SHALL remain stable until the transfer occurs.

Reset
REQ-028: With rst_n=0 at a clock edge, the block SHALL set:
- full[0]=full[1]=0
- wr_bank=rd_bank=0
- wr_cnt=rd_idx=0
REQ-029: During and after reset, the outputs SHALL read stall=0, out_valid=0, out_last=0, out_r=out_i=0 and out_idx=0.
REQ-030: A reset mid-frame SHALL discard all partial and buffered frames; bank memory contents need not be cleared.

Configuration
REQ-031: Macro FFT_REORDER_BITREV_EN.
- Defined: the write address SHALL be the bit-reverse of wr_cnt ({wr_cnt[0],wr_cnt[1],wr_cnt[2],wr_cnt[3]}), converting the FFT's bit-reversed output order to natural order.
- Undefined: the write address SHALL equal wr_cnt (pass-through order); all other behaviour is identical.

Verification
REQ-032: Bitrev defined, out_ready=1, one frame with X_r=k and X_i=-k for arrival k=0..15 -> outputs in the order below, with out_last at idx 15 and out_valid rising 1 cycle after the 16th accept:
- idx0 -> X_r=0
- idx1 -> X_r=8
- idx2 -> X_r=4
- idx3 -> X_r=12
- ...
- idx15 -> X_r=15
REQ-033: Bitrev undefined, same stimulus -> out_r=n and out_i=-n at out_idx=n.
REQ-034: out_ready=0, valid_out=1 continuously -> stall=1 exactly from the cycle after the 32nd accept; then out_ready=1 -> 16 transfers, stall drops the cycle after the 16th transfer, and the third frame is accepted without loss.
REQ-035: out_ready toggling 1/0 every cycle with continuous input -> every frame is output complete and in order; out_data is stable while out_valid=1 and out_ready=0.
REQ-036: rst_n=0 for one cycle after 7 accepts of a frame -> the next cycle shows stall=0 and out_valid=0, and the next 16 accepts form a complete frame at idx 0..15.
REQ-037: Input values of -2048 and 2047 (DATA_WIDTH=12) -> reproduced bit-exact at the output.

Source files
------------

// File: rtl/fft_out_reorder.sv
// fft_out_reorder
//   Two-bank ping-pong reorder buffer behind a 16-point FFT. Samples arriving
//   from the FFT are written into the current write bank. Once a bank holds a
//   full frame, it is streamed out in natural bin order under a valid/ready
//   handshake. When both banks are full, the FFT pipeline is frozen through
//   the stall output.
//
//   Optional feature macro: FFT_REORDER_BITREV_EN
//     defined   : write address = bit-reverse of the arrival count
//                 (converts bit-reversed FFT output to natural order)
//     undefined : write address = arrival count (pass-through order)
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   valid_out  in   FFT sample valid
//   X_r, X_i   in   FFT sample (signed, DATA_WIDTH)
//   stall      out  freeze request to the FFT (registered state only)
//   out_ready  in   downstream accepts a sample
//   out_valid  out  output sample valid
//   out_r/i    out  reordered sample, 0 while out_valid=0
//   out_idx    out  natural-order bin index
//   out_last   out  last bin of the frame (idx 15)
module fft_out_reorder #(
  parameter int DATA_WIDTH = 12
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         valid_out,
  input  logic signed [DATA_WIDTH-1:0] X_r,
  input  logic signed [DATA_WIDTH-1:0] X_i,
  output logic                         stall,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic signed [DATA_WIDTH-1:0] out_r,
  output logic signed [DATA_WIDTH-1:0] out_i,
  output logic [3:0]                   out_idx,
  output logic                         out_last
);

  logic signed [DATA_WIDTH-1:0] r_mem_r [2][16];
  logic signed [DATA_WIDTH-1:0] r_mem_i [2][16];

  logic [1:0] r_full;
  logic       r_wr_bank;
  logic       r_rd_bank;
  logic [3:0] r_wr_cnt;
  logic [3:0] r_rd_idx;

  logic       w_accept;
  logic       w_xfer;
  logic       w_wr_done;
  logic       w_rd_done;
  logic [3:0] w_wr_addr;
  logic [1:0] w_full_nxt;

`ifdef FFT_REORDER_BITREV_EN
  assign w_wr_addr = {r_wr_cnt[0], r_wr_cnt[1], r_wr_cnt[2], r_wr_cnt[3]};
`else
  assign w_wr_addr = r_wr_cnt;
`endif

  assign stall     = r_full[r_wr_bank];
  assign out_valid = r_full[r_rd_bank];
  assign w_accept  = valid_out & ~stall;
  assign w_xfer    = out_valid & out_ready;
  assign w_wr_done = w_accept & (r_wr_cnt == 4'd15);
  assign w_rd_done = w_xfer & (r_rd_idx == 4'd15);

  // Set targets the write bank (which is empty when written) and clear targets
  // the read bank (which is full when read), so both can apply on one edge.
  always_comb begin
    w_full_nxt = r_full;
    if (w_wr_done) w_full_nxt[r_wr_bank] = 1'b1;
    if (w_rd_done) w_full_nxt[r_rd_bank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_full    <= '0;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_wr_cnt  <= '0;
      r_rd_idx  <= '0;
    end else begin
      r_full <= w_full_nxt;
      if (w_accept) begin
        r_wr_cnt <= r_wr_cnt + 4'd1;
        if (w_wr_done) r_wr_bank <= ~r_wr_bank;
      end
      if (w_xfer) begin
        r_rd_idx <= r_rd_idx + 4'd1;
        if (w_rd_done) r_rd_bank <= ~r_rd_bank;
      end
    end
  end

  // Sample storage is not reset; the full flags alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem_r[r_wr_bank][w_wr_addr] <= X_r;
      r_mem_i[r_wr_bank][w_wr_addr] <= X_i;
    end
  end

  always_comb begin
    out_r = '0;
    out_i = '0;
    if (out_valid) begin
      out_r = r_mem_r[r_rd_bank][r_rd_idx];
      out_i = r_mem_i[r_rd_bank][r_rd_idx];
    end
  end

  assign out_idx  = r_rd_idx;
  assign out_last = out_valid & (r_rd_idx == 4'd15);

endmodule

// File: tb/tb_fft_out_reorder.sv
module tb_fft_out_reorder;
  localparam int DW = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic                 valid_out;
  logic signed [DW-1:0] X_r;
  logic signed [DW-1:0] X_i;
  logic                 stall;
  logic                 out_ready;
  logic                 out_valid;
  logic signed [DW-1:0] out_r;
  logic signed [DW-1:0] out_i;
  logic [3:0]           out_idx;
  logic                 out_last;

  fft_out_reorder #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .valid_out(valid_out), .X_r(X_r), .X_i(X_i),
    .stall(stall), .out_ready(out_ready), .out_valid(out_valid),
    .out_r(out_r), .out_i(out_i), .out_idx(out_idx), .out_last(out_last)
  );

  typedef struct packed {
    logic signed [DW-1:0] r;
    logic signed [DW-1:0] i;
  } samp_t;

  // Reference model: queue of natural-order samples of completed frames,
  // the partial frame being collected, and the position within the head frame.
  samp_t q[$];
  samp_t part[16];
  int    wr_n   = 0;
  int    rd_pos = 0;
  bit    m_acc  = 1'b0;

  int checks = 0;
  int errors = 0;
  int rmode  = 0;   // 0: fixed ready, 1: toggle, 2: random
  bit rfix   = 1'b0;

`ifdef FFT_REORDER_BITREV_EN
  int LIT[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
`else
  int LIT[16] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
`endif

  function automatic int addr_of(input int k);
`ifdef FFT_REORDER_BITREV_EN
    return ((k & 1) << 3) | ((k & 2) << 1) | ((k & 4) >> 1) | ((k & 8) >> 3);
`else
    return k;
`endif
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int frames_buffered();
    return (q.size() + 15) / 16;
  endfunction

  task automatic model_edge();
    int    nb;
    bit    m_stall;
    bit    m_valid;
    samp_t nat[16];
    m_acc = 1'b0;
    if (!rst_n) begin
      q.delete();
      wr_n   = 0;
      rd_pos = 0;
    end else begin
      nb      = frames_buffered();
      m_stall = (nb == 2);
      m_valid = (nb >= 1);
      if (m_valid && out_ready) begin
        void'(q.pop_front());
        rd_pos = (rd_pos + 1) % 16;
      end
      if (valid_out && !m_stall) begin
        m_acc = 1'b1;
        part[wr_n] = '{r: X_r, i: X_i};
        wr_n++;
        if (wr_n == 16) begin
          for (int k = 0; k < 16; k++) nat[addr_of(k)] = part[k];
          for (int n = 0; n < 16; n++) q.push_back(nat[n]);
          wr_n = 0;
        end
      end
    end
  endtask

  task automatic check_outputs();
    int nb;
    bit v;
    nb = frames_buffered();
    v  = (nb >= 1);
    chk("stall", int'(stall), int'(nb == 2));
    chk("out_valid", int'(out_valid), int'(v));
    chk("out_idx", int'(out_idx), rd_pos);
    chk("out_last", int'(out_last), int'(v && rd_pos == 15));
    chk("out_r", int'(out_r), v ? int'(q[0].r) : 0);
    chk("out_i", int'(out_i), v ? int'(q[0].i) : 0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
    case (rmode)
      0:       out_ready = rfix;
      1:       out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic offer(input logic signed [DW-1:0] r, input logic signed [DW-1:0] i,
                       output int waited);
    valid_out = 1'b1;
    X_r = r;
    X_i = i;
    waited = 0;
    do begin
      tick();
      waited++;
    end while (!m_acc && waited < 200);
    chk("accept_in_time", int'(m_acc), 1);
  endtask

  task automatic idle(input int n);
    valid_out = 1'b0;
    for (int c = 0; c < n; c++) tick();
  endtask

  function automatic logic signed [DW-1:0] rnd();
    return DW'($urandom());
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst_n = 1'b0; valid_out = 1'b0; out_ready = 1'b0;
    X_r = '0; X_i = '0;
    rmode = 0; rfix = 1'b0;
    tick(); tick();
    chk("rst_stall", int'(stall), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_last", int'(out_last), 0);
    chk("rst_r", int'(out_r), 0);
    chk("rst_i", int'(out_i), 0);
    chk("rst_idx", int'(out_idx), 0);
    rst_n = 1'b1;

    // Directed ramp frame, pinned against a literal order table
    rfix = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 16; k++) offer(DW'(k), DW'(-k), w);
    chk("latency_valid", int'(out_valid), 1);
    valid_out = 1'b0;
    for (int n = 0; n < 16; n++) begin
      chk("lit_idx", int'(out_idx), n);
      chk("lit_r", int'(out_r), LIT[n]);
      chk("lit_i", int'(out_i), -LIT[n]);
      chk("lit_last", int'(out_last), int'(n == 15));
      tick();
    end
    chk("lit_drained", int'(out_valid), 0);

    // Fill both banks with downstream blocked, then release
    rfix = 1'b0; out_ready = 1'b0;
    for (int k = 0; k < 32; k++) begin
      offer(rnd(), rnd(), w);
      if (k == 30) chk("stall_before_32", int'(stall), 0);
    end
    chk("stall_after_32", int'(stall), 1);
    rfix = 1'b1; out_ready = 1'b1;
    offer(rnd(), rnd(), w);
    chk("stall_release_cycles", w, 17);
    for (int k = 0; k < 15; k++) offer(rnd(), rnd(), w);
    idle(60);

    // Ready toggling every cycle with continuous input
    rmode = 1;
    for (int k = 0; k < 48; k++) offer(rnd(), rnd(), w);
    rmode = 0; rfix = 1'b1;
    idle(60);

    // Reset mid-frame with a buffered frame pending
    rfix = 1'b0; out_ready = 1'b0;
    for (int k = 0; k < 23; k++) offer(rnd(), rnd(), w);
    rst_n = 1'b0; valid_out = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_stall", int'(stall), 0);
    chk("midrst_valid", int'(out_valid), 0);
    for (int k = 0; k < 16; k++) offer(rnd(), rnd(), w);
    chk("midrst_frame_valid", int'(out_valid), 1);
    chk("midrst_frame_idx", int'(out_idx), 0);
    rfix = 1'b1; out_ready = 1'b1;
    idle(30);

    // Extreme values reproduced bit-exact
    for (int k = 0; k < 16; k++)
      offer((k % 2 == 1) ? DW'(2047) : DW'(-2048), (k % 2 == 1) ? DW'(-2048) : DW'(2047), w);
    valid_out = 1'b0;
    for (int n = 0; n < 16; n++) begin
      chk("ext_r", int'(out_r), (LIT[n] % 2 == 1) ? 2047 : -2048);
      chk("ext_i", int'(out_i), (LIT[n] % 2 == 1) ? -2048 : 2047);
      tick();
    end

    // Random traffic
    rmode = 2;
    for (int it = 0; it < 700; it++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      else offer(rnd(), rnd(), w);
    end
    rmode = 0; rfix = 1'b1;
    idle(60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
